solver_csr_bank: RTL and testbench
==================================

Name: solver_csr_bank

Overview:
- Parametrised MMIO control/status register bank driving NUM_CH independent ODE solver channels from one AFU.
- Decodes host MMIO reads and writes. Holds per-channel solver configuration and runs a per-channel start/run/done state machine. Counts run cycles and returns results and status.
- Sits between the CCI-P MMIO unpacking logic and the solver instances. It supersedes the fixed single-solver register set.

Parameters:
- NUM_CH, 4, number of solver channels (1..16).
- CH_BASE, 16'h0040, qword-word address of channel 0 register window.
- CH_STRIDE, 16'h0020, address distance between channel windows (power of two, >= 16'h0020).
- CNT_W, 48, width of per-channel run-cycle counter.
- AFU_ID, 128'h0, value returned at AFU_ID_L/H.

Ports:
- clk  in  1  core clock; all logic synchronous to it.
- reset  in  1  asynchronous, active-low reset.
- mmio_wr_valid  in  1  MMIO write strobe, single cycle.
- mmio_rd_valid  in  1  MMIO read strobe, single cycle.
- mmio_addr  in  16  MMIO address in 4-byte units, qword aligned.
- mmio_tid  in  9  read transaction ID.
- mmio_wr_data  in  64  write data.
- rd_valid  out  1  read response valid, one cycle.
- rd_tid  out  9  echoed TID.
- rd_data  out  64  read response data.
- solver_enb  out  NUM_CH  per-channel run enable.
- solver_fin  in  NUM_CH  per-channel finish, sampled in RUN only.
- solver_h, solver_x_start, solver_y_start_val  out  64*NUM_CH  per-channel configuration, channel c at [64c+63:64c].
- solver_n, solver_y_start_addr, solver_y_addr  out  32*NUM_CH  per-channel configuration, channel c at [32c+31:32c].
- solver_x, solver_y_val  in  64*NUM_CH  per-channel results.

Behaviour:
- Reset (reset=0, asynchronous): all outputs, configuration registers, counters and errors are 0. All channels enter IDLE. rd_valid=0.
- Global map:
  - 0x0000: DFH (type AFU, end-of-list=1, other fields 0).
  - 0x0002 / 0x0004: AFU_ID[63:0] / AFU_ID[127:64].
  - 0x0006 / 0x0008: 0.
  - 0x0010: {48'h0, 8'(NUM_CH), 8'h02 version}.
  - 0x0012: DONE bitmap, NUM_CH bits zero-extended. A write to 0x0012 is W1C: each channel whose bit is 1 moves from DONE to IDLE.
- Channel c window at CH_BASE + c*CH_STRIDE; offsets:
  - 0x00 H, 0x02 N, 0x04 X_START, 0x06 Y_START_ADDR, 0x08 Y_START_VAL, 0x0A Y_ADDR. All read/write; 32-bit registers take data[31:0] and read zero-extended.
  - 0x0C CTRL (write only; reads 0): bit0 START, bit1 ABORT.
  - 0x0E STATUS: {60'h0, err, done, busy, 1'b0}.
  - 0x10 X result, 0x12 Y_VAL result (read only).
  - 0x14 CYCLES, zero-extended from CNT_W bits.
- Unmapped addresses, and channel windows with index >= NUM_CH: reads return 0, writes are dropped.
- Read latency is exactly 1 cycle: rd_valid, rd_tid and rd_data are registered. rd_data holds its last value when rd_valid=0.
- A read and a write in the same cycle are both served. The read returns the pre-write value.
- Per-channel FSM:
  - IDLE --START--> RUN. On that edge CYCLES clears and err clears.
  - RUN --fin--> DONE.
  - RUN --ABORT--> IDLE.
  - DONE --START--> RUN.
  - DONE --W1C--> IDLE.
- solver_enb[c]=1 exactly while in RUN; it rises on the cycle after the START write.
- busy = (state==RUN); done = (state==DONE).
- CYCLES increments by 1 every cycle in RUN and saturates at all-ones. It is held in DONE and IDLE.
- Configuration writes while in RUN are dropped and set err. Configuration outputs are stable for the whole run.
- START while in RUN is ignored and sets err. ABORT in IDLE or DONE has no effect.
- START and ABORT both set in one write: ABORT wins, and the channel does not start.
- fin and ABORT in the same cycle: fin wins, and the channel goes to DONE.
- fin outside RUN is ignored.
- W1C in the same cycle as fin: the channel ends in DONE (fin wins).
- Channels are fully independent; any number can be in RUN simultaneously.

Test Plan:
- Reset then read 0x0000, 0x0010 -> DFH 64'h1000_0100_0000_0000; 0x0010 = 64'h0402 for NUM_CH=4. Each read gives rd_valid exactly 1 cycle after the request, with the matching tid.
- Ch1: write H=64'h3F50624DD2F1A9FC, N=100, START; hold fin[1]=0 for 10 cycles, then pulse fin.
  - solver_enb[1]=1 for 11 cycles.
  - STATUS reads 0x4 (done) with CYCLES=11.
  - DONE bitmap = 4'b0010.
- While ch1 is RUN: write N=5 to ch1 -> N still 100, STATUS err=1. Write START -> no restart; CYCLES keeps counting.
- Ch0 and ch3 started together; abort ch0 in the same cycle fin[3] pulses -> ch0 IDLE with STATUS 0; ch3 DONE. Write 0x0012 = 4'b1000 -> ch3 IDLE and bitmap 0.
- Read/write to channel window 5 (NUM_CH=4) and to address 0x0018 -> read 0, no register changes.
- Assert reset mid-run on ch2 -> solver_enb goes to 0 asynchronously, all registers read 0 after release.

Source files
------------

// File: rtl/solver_csr_bank_if.sv
// MMIO request/response bundle between the CCI-P MMIO unpacker (master) and the
// solver CSR bank (slave).
interface solver_csr_bank_if;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic        rd_valid;
  logic [8:0]  rd_tid;
  logic [63:0] rd_data;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    input  rd_valid, rd_tid, rd_data
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data,
    output rd_valid, rd_tid, rd_data
  );
endinterface

// File: rtl/solver_csr_bank.sv
// MMIO control/status register bank for NUM_CH independent ODE solver channels:
// per-channel configuration, start/run/done control, run-cycle counters and readback.
module solver_csr_bank #(
  parameter int             NUM_CH    = 4,
  parameter logic [15:0]    CH_BASE   = 16'h0040,
  parameter logic [15:0]    CH_STRIDE = 16'h0020,
  parameter int             CNT_W     = 48,
  parameter logic [127:0]   AFU_ID    = 128'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  solver_csr_bank_if.slave      mmio,
  output logic [NUM_CH-1:0]     solver_enb,
  input  logic [NUM_CH-1:0]     solver_fin,
  output logic [64*NUM_CH-1:0]  solver_h,
  output logic [64*NUM_CH-1:0]  solver_x_start,
  output logic [64*NUM_CH-1:0]  solver_y_start_val,
  output logic [32*NUM_CH-1:0]  solver_n,
  output logic [32*NUM_CH-1:0]  solver_y_start_addr,
  output logic [32*NUM_CH-1:0]  solver_y_addr,
  input  logic [64*NUM_CH-1:0]  solver_x,
  input  logic [64*NUM_CH-1:0]  solver_y_val
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} ch_state_e;

  localparam int          STRIDE_SH = $clog2(CH_STRIDE);
  localparam logic [63:0] DFH_VAL   = 64'h1000_0100_0000_0000;
  localparam logic [15:0] ADDR_DFH  = 16'h0000;
  localparam logic [15:0] ADDR_IDL  = 16'h0002;
  localparam logic [15:0] ADDR_IDH  = 16'h0004;
  localparam logic [15:0] ADDR_INFO = 16'h0010;
  localparam logic [15:0] ADDR_DONE = 16'h0012;

  localparam logic [15:0] OFF_H     = 16'h00;
  localparam logic [15:0] OFF_N     = 16'h02;
  localparam logic [15:0] OFF_XS    = 16'h04;
  localparam logic [15:0] OFF_YSA   = 16'h06;
  localparam logic [15:0] OFF_YSV   = 16'h08;
  localparam logic [15:0] OFF_YA    = 16'h0A;
  localparam logic [15:0] OFF_CTRL  = 16'h0C;
  localparam logic [15:0] OFF_STAT  = 16'h0E;
  localparam logic [15:0] OFF_X     = 16'h10;
  localparam logic [15:0] OFF_YV    = 16'h12;
  localparam logic [15:0] OFF_CYC   = 16'h14;

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [63:0]      h_q     [NUM_CH], h_d     [NUM_CH];
  logic [63:0]      xs_q    [NUM_CH], xs_d    [NUM_CH];
  logic [63:0]      ysv_q   [NUM_CH], ysv_d   [NUM_CH];
  logic [31:0]      n_q     [NUM_CH], n_d     [NUM_CH];
  logic [31:0]      ysa_q   [NUM_CH], ysa_d   [NUM_CH];
  logic [31:0]      ya_q    [NUM_CH], ya_d    [NUM_CH];
  logic [CNT_W-1:0] cyc_q   [NUM_CH], cyc_d   [NUM_CH];
  logic             err_q   [NUM_CH], err_d   [NUM_CH];

  logic        rd_valid_q, rd_valid_d;
  logic [8:0]  rd_tid_q,   rd_tid_d;
  logic [63:0] rd_data_q,  rd_data_d;

  logic [15:0] ch_off, ch_idx, ch_reg;
  logic        ch_sel;
  logic [NUM_CH-1:0] wr_cfg, start_ok, abort, w1c, busy, done;

  // Address decode shared by the read and write paths.
  always_comb begin
    ch_off = mmio.mmio_addr - CH_BASE;
    ch_idx = ch_off >> STRIDE_SH;
    ch_reg = ch_off & (CH_STRIDE - 16'd1);
    ch_sel = (mmio.mmio_addr >= CH_BASE) && (ch_idx < 16'(NUM_CH));
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wr_cfg   = '0;
    start_ok = '0;
    abort    = '0;
    w1c      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic hit;
      hit = mmio.mmio_wr_valid && ch_sel && (ch_idx == 16'(c));
      wr_cfg[c]   = hit && (ch_reg inside {OFF_H, OFF_N, OFF_XS, OFF_YSA, OFF_YSV, OFF_YA});
      abort[c]    = hit && (ch_reg == OFF_CTRL) && mmio.mmio_wr_data[1];
      start_ok[c] = hit && (ch_reg == OFF_CTRL) && mmio.mmio_wr_data[0] && !mmio.mmio_wr_data[1];
      w1c[c]      = mmio.mmio_wr_valid && (mmio.mmio_addr == ADDR_DONE) && mmio.mmio_wr_data[c];
    end
  end

  // Channel FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= ST_IDLE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
    end
  end

  // Channel FSM: next state. fin outranks ABORT and W1C.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        ST_IDLE: if (start_ok[c]) state_d[c] = ST_RUN;
        ST_RUN: begin
          if (solver_fin[c])  state_d[c] = ST_DONE;
          else if (abort[c])  state_d[c] = ST_IDLE;
        end
        ST_DONE: begin
          if (start_ok[c])    state_d[c] = ST_RUN;
          else if (w1c[c])    state_d[c] = ST_IDLE;
        end
        default:              state_d[c] = ST_IDLE;
      endcase
    end
  end

  // Channel FSM: outputs decoded straight from the state register.
  always_comb begin
    solver_enb = '0;
    busy       = '0;
    done       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      solver_enb[c] = (state_q[c] == ST_RUN);
      busy[c]       = (state_q[c] == ST_RUN);
      done[c]       = (state_q[c] == ST_DONE);
    end
  end

  // Configuration, counters and error flags.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      logic launch;
      h_d[c]   = h_q[c];
      xs_d[c]  = xs_q[c];
      ysv_d[c] = ysv_q[c];
      n_d[c]   = n_q[c];
      ysa_d[c] = ysa_q[c];
      ya_d[c]  = ya_q[c];
      cyc_d[c] = cyc_q[c];
      err_d[c] = err_q[c];
      launch   = start_ok[c] && (state_q[c] != ST_RUN);

      if (state_q[c] == ST_RUN) begin
        if (!(&cyc_q[c])) cyc_d[c] = cyc_q[c] + CNT_W'(1);
        if (wr_cfg[c] || start_ok[c]) err_d[c] = 1'b1;
      end else begin
        if (launch) begin
          cyc_d[c] = '0;
          err_d[c] = 1'b0;
        end
        if (wr_cfg[c]) begin
          case (ch_reg)
            OFF_H:   h_d[c]   = mmio.mmio_wr_data;
            OFF_N:   n_d[c]   = mmio.mmio_wr_data[31:0];
            OFF_XS:  xs_d[c]  = mmio.mmio_wr_data;
            OFF_YSA: ysa_d[c] = mmio.mmio_wr_data[31:0];
            OFF_YSV: ysv_d[c] = mmio.mmio_wr_data;
            OFF_YA:  ya_d[c]  = mmio.mmio_wr_data[31:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux sees only registered values, so a same-cycle write is not visible yet.
  always_comb begin
    logic [63:0] rd_mux;
    rd_mux = '0;
    case (mmio.mmio_addr)
      ADDR_DFH:  rd_mux = DFH_VAL;
      ADDR_IDL:  rd_mux = AFU_ID[63:0];
      ADDR_IDH:  rd_mux = AFU_ID[127:64];
      ADDR_INFO: rd_mux = {48'h0, 8'(NUM_CH), 8'h02};
      ADDR_DONE: rd_mux = 64'(done);
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_sel && (ch_idx == 16'(c))) begin
            case (ch_reg)
              OFF_H:    rd_mux = h_q[c];
              OFF_N:    rd_mux = 64'(n_q[c]);
              OFF_XS:   rd_mux = xs_q[c];
              OFF_YSA:  rd_mux = 64'(ysa_q[c]);
              OFF_YSV:  rd_mux = ysv_q[c];
              OFF_YA:   rd_mux = 64'(ya_q[c]);
              OFF_STAT: rd_mux = {60'h0, err_q[c], done[c], busy[c], 1'b0};
              OFF_X:    rd_mux = solver_x[64*c +: 64];
              OFF_YV:   rd_mux = solver_y_val[64*c +: 64];
              OFF_CYC:  rd_mux = 64'(cyc_q[c]);
              default:  rd_mux = '0;
            endcase
          end
        end
      end
    endcase
    rd_valid_d = mmio.mmio_rd_valid;
    rd_tid_d   = mmio.mmio_rd_valid ? mmio.mmio_tid : rd_tid_q;
    rd_data_d  = mmio.mmio_rd_valid ? rd_mux : rd_data_q;
  end

  // NOTE: the per-channel register arrays are individual flops, so they reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        h_q[c]   <= '0;
        xs_q[c]  <= '0;
        ysv_q[c] <= '0;
        n_q[c]   <= '0;
        ysa_q[c] <= '0;
        ya_q[c]  <= '0;
        cyc_q[c] <= '0;
        err_q[c] <= 1'b0;
      end
      rd_valid_q <= 1'b0;
      rd_tid_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        h_q[c]   <= h_d[c];
        xs_q[c]  <= xs_d[c];
        ysv_q[c] <= ysv_d[c];
        n_q[c]   <= n_d[c];
        ysa_q[c] <= ysa_d[c];
        ya_q[c]  <= ya_d[c];
        cyc_q[c] <= cyc_d[c];
        err_q[c] <= err_d[c];
      end
      rd_valid_q <= rd_valid_d;
      rd_tid_q   <= rd_tid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    solver_h            = '0;
    solver_x_start      = '0;
    solver_y_start_val  = '0;
    solver_n            = '0;
    solver_y_start_addr = '0;
    solver_y_addr       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      solver_h[64*c +: 64]            = h_q[c];
      solver_x_start[64*c +: 64]      = xs_q[c];
      solver_y_start_val[64*c +: 64]  = ysv_q[c];
      solver_n[32*c +: 32]            = n_q[c];
      solver_y_start_addr[32*c +: 32] = ysa_q[c];
      solver_y_addr[32*c +: 32]       = ya_q[c];
    end
  end

  assign mmio.rd_valid = rd_valid_q;
  assign mmio.rd_tid   = rd_tid_q;
  assign mmio.rd_data  = rd_data_q;

endmodule

// File: tb/tb_solver_csr_bank.sv
// Directed bench for solver_csr_bank (NUM_CH=4): global map, channel run/abort/done
// sequencing, error flags, unmapped accesses and asynchronous reset.
module tb_solver_csr_bank;
  localparam int NUM_CH = 4;
  localparam logic [63:0] H1 = 64'h3F50624DD2F1A9FC;
  localparam logic [63:0] X1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] Y1 = 64'h0000_0000_0000_CAFE;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  solver_csr_bank_if mmio ();

  logic [NUM_CH-1:0]    solver_enb, solver_fin;
  logic [64*NUM_CH-1:0] solver_h, solver_x_start, solver_y_start_val, solver_x, solver_y_val;
  logic [32*NUM_CH-1:0] solver_n, solver_y_start_addr, solver_y_addr;

  solver_csr_bank #(.NUM_CH(NUM_CH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .mmio                (mmio),
    .solver_enb          (solver_enb),
    .solver_fin          (solver_fin),
    .solver_h            (solver_h),
    .solver_x_start      (solver_x_start),
    .solver_y_start_val  (solver_y_start_val),
    .solver_n            (solver_n),
    .solver_y_start_addr (solver_y_start_addr),
    .solver_y_addr       (solver_y_addr),
    .solver_x            (solver_x),
    .solver_y_val        (solver_y_val)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int enb1_cnt = 0;
  logic [8:0] tid_next = 9'h0A0;

  always @(negedge clk) if (solver_enb[1]) enb1_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Callers sit 1 time unit after a rising edge.
  task automatic wr(input logic [15:0] addr, input logic [63:0] data);
    mmio.mmio_wr_valid = 1'b1;
    mmio.mmio_addr     = addr;
    mmio.mmio_wr_data  = data;
    @(posedge clk); #1;
    mmio.mmio_wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [63:0] exp);
    logic [8:0] tid;
    tid = tid_next;
    tid_next = tid_next + 9'd3;
    mmio.mmio_rd_valid = 1'b1;
    mmio.mmio_addr     = addr;
    mmio.mmio_tid      = tid;
    @(posedge clk); #1;
    mmio.mmio_rd_valid = 1'b0;
    check({tag, ".vld"},  64'(mmio.rd_valid), 64'd1);
    check({tag, ".tid"},  64'(mmio.rd_tid),   64'(tid));
    check({tag, ".data"}, mmio.rd_data,       exp);
    @(posedge clk); #1;
    check({tag, ".vld_off"}, 64'(mmio.rd_valid), 64'd0);
    check({tag, ".hold"},    mmio.rd_data,       exp);
  endtask

  function automatic logic [15:0] ch_addr(input int c, input logic [15:0] off);
    return 16'h0040 + 16'(c) * 16'h0020 + off;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    mmio.mmio_wr_valid = 1'b0;
    mmio.mmio_rd_valid = 1'b0;
    mmio.mmio_addr     = '0;
    mmio.mmio_tid      = '0;
    mmio.mmio_wr_data  = '0;
    solver_fin   = '0;
    solver_x     = '0;
    solver_y_val = '0;
    solver_x[127:64]     = X1;
    solver_y_val[127:64] = Y1;

    repeat (3) @(posedge clk);
    #1;
    check("rst.enb",      64'(solver_enb),     64'd0);
    check("rst.rd_valid", 64'(mmio.rd_valid),  64'd0);
    check("rst.h",        solver_h[63:0],      64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Global map
    rd("dfh",  16'h0000, 64'h1000_0100_0000_0000);
    rd("idl",  16'h0002, 64'h0);
    rd("info", 16'h0010, 64'h0402);
    rd("done0", 16'h0012, 64'h0);

    // Ch1 configure and single run of 11 RUN cycles
    wr(ch_addr(1, 16'h00), H1);
    wr(ch_addr(1, 16'h02), 64'hFFFF_FFFF_0000_0064);
    check("ch1.h_out", solver_h[127:64], H1);
    check("ch1.n_out", 64'(solver_n[63:32]), 64'd100);
    check("ch0.h_out", solver_h[63:0], 64'd0);
    wr(ch_addr(1, 16'h0C), 64'h1);
    check("ch1.enb_rise", 64'(solver_enb), 64'b0010);
    base = enb1_cnt;
    repeat (10) @(posedge clk);
    #1;
    solver_fin[1] = 1'b1;
    @(posedge clk); #1;
    solver_fin[1] = 1'b0;
    check("ch1.enb_cycles", 64'(enb1_cnt - base), 64'd11);
    check("ch1.enb_fall",   64'(solver_enb[1]),   64'd0);
    rd("ch1.status", ch_addr(1, 16'h0E), 64'h4);
    rd("ch1.cycles", ch_addr(1, 16'h14), 64'd11);
    rd("ch1.done_map", 16'h0012, 64'b0010);
    rd("ch1.h_rd", ch_addr(1, 16'h00), H1);
    rd("ch1.n_rd", ch_addr(1, 16'h02), 64'd100);
    rd("ch1.x_rd", ch_addr(1, 16'h10), X1);
    rd("ch1.y_rd", ch_addr(1, 16'h12), Y1);
    rd("ch1.ctrl_rd", ch_addr(1, 16'h0C), 64'h0);

    // Ch1 restart from DONE; config write and START while RUN
    wr(ch_addr(1, 16'h0C), 64'h1);
    wr(ch_addr(1, 16'h02), 64'd5);
    check("ch1.n_locked", 64'(solver_n[63:32]), 64'd100);
    rd("ch1.status_err", ch_addr(1, 16'h0E), 64'hA);
    rd("ch1.cyc_a", ch_addr(1, 16'h14), 64'd3);
    wr(ch_addr(1, 16'h0C), 64'h1);
    rd("ch1.cyc_b", ch_addr(1, 16'h14), 64'd6);
    check("ch1.still_run", 64'(solver_enb[1]), 64'd1);
    solver_fin[1] = 1'b1;
    @(posedge clk); #1;
    solver_fin[1] = 1'b0;
    rd("ch1.status_done_err", ch_addr(1, 16'h0E), 64'hC);
    wr(16'h0012, 64'b0010);
    rd("ch1.status_idle_err", ch_addr(1, 16'h0E), 64'h8);

    // Ch0/ch3: abort ch0 in the cycle fin[3] pulses
    wr(ch_addr(0, 16'h0C), 64'h1);
    wr(ch_addr(3, 16'h0C), 64'h1);
    check("ch03.enb", 64'(solver_enb), 64'b1001);
    solver_fin[3] = 1'b1;
    wr(ch_addr(0, 16'h0C), 64'h2);
    solver_fin[3] = 1'b0;
    check("ch03.enb_off", 64'(solver_enb), 64'b0000);
    rd("ch0.status_abort", ch_addr(0, 16'h0E), 64'h0);
    rd("ch3.status_done",  ch_addr(3, 16'h0E), 64'h4);
    rd("ch3.done_map", 16'h0012, 64'b1000);
    wr(16'h0012, 64'b1000);
    rd("ch3.done_map_clr", 16'h0012, 64'h0);
    rd("ch3.status_idle",  ch_addr(3, 16'h0E), 64'h0);

    // Ch2: fin beats ABORT, fin beats W1C
    wr(ch_addr(2, 16'h0C), 64'h1);
    solver_fin[2] = 1'b1;
    wr(ch_addr(2, 16'h0C), 64'h2);
    solver_fin[2] = 1'b0;
    rd("ch2.fin_vs_abort", ch_addr(2, 16'h0E), 64'h4);
    wr(ch_addr(2, 16'h0C), 64'h1);
    solver_fin[2] = 1'b1;
    wr(16'h0012, 64'b0100);
    solver_fin[2] = 1'b0;
    rd("ch2.fin_vs_w1c", ch_addr(2, 16'h0E), 64'h4);
    wr(16'h0012, 64'b0100);
    rd("ch2.done_map_clr", 16'h0012, 64'h0);

    // Ch0: START+ABORT together in IDLE, fin outside RUN
    wr(ch_addr(0, 16'h0C), 64'h3);
    check("ch0.start_abort_enb", 64'(solver_enb[0]), 64'd0);
    solver_fin[0] = 1'b1;
    @(posedge clk); #1;
    solver_fin[0] = 1'b0;
    rd("ch0.status_idle", ch_addr(0, 16'h0E), 64'h0);

    // Unmapped accesses: windows 4 and 5, global hole 0x0018
    wr(ch_addr(5, 16'h00), 64'hDEAD_BEEF_0000_0001);
    wr(ch_addr(4, 16'h00), 64'hDEAD_BEEF_0000_0002);
    wr(16'h0018, 64'hDEAD_BEEF_0000_0003);
    check("unmap.ch1_h", solver_h[127:64], H1);
    check("unmap.ch0_h", solver_h[63:0],   64'd0);
    rd("unmap.win5", ch_addr(5, 16'h00), 64'h0);
    rd("unmap.0018", 16'h0018, 64'h0);

    // Reset mid-run on ch2
    wr(ch_addr(2, 16'h0C), 64'h1);
    repeat (3) @(posedge clk);
    #1;
    check("ch2.running", 64'(solver_enb[2]), 64'd1);
    reset = 1'b0;
    #1;
    check("arst.enb",  64'(solver_enb),        64'd0);
    check("arst.h1",   solver_h[127:64],       64'd0);
    check("arst.n1",   64'(solver_n[63:32]),   64'd0);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    rd("post.h1",     ch_addr(1, 16'h00), 64'h0);
    rd("post.stat2",  ch_addr(2, 16'h0E), 64'h0);
    rd("post.cyc2",   ch_addr(2, 16'h14), 64'h0);
    rd("post.stat1",  ch_addr(1, 16'h0E), 64'h0);
    rd("post.done",   16'h0012, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
